// File: rtl/jpeg_scan_bit_buffer.sv
// JPEG entropy-coded-segment front end: removes byte stuffing and fill bytes,
// halts on markers and offers an MSB-aligned bit window to the Huffman decoder.
module jpeg_scan_bit_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_scan,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [15:0] peek_bits,
    output logic [5:0]  bits_avail,
    input  logic        consume_valid,
    input  logic [4:0]  consume_len,
    output logic        consume_err,
    output logic        marker_valid,
    output logic [7:0]  marker_code,
    input  logic        marker_ack,
    output logic        eoi_seen
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_FF     = 2'd2;
    localparam logic [1:0] ST_MARKER = 2'd3;

    logic [1:0]  state_r, state_next_s;
    logic [31:0] buf_r, buf_next_s;
    logic [5:0]  avail_r, avail_next_s;
    logic        err_r, err_next_s;
    logic        mv_r, mv_next_s;
    logic [7:0]  mc_r, mc_next_s;
    logic        eoi_r, eoi_next_s;

    logic        accept_s;
    logic        cons_ok_s;
    logic        cons_bad_s;
    logic [31:0] shifted_s;
    logic [5:0]  avail_after_s;
    logic        append_s;
    logic [7:0]  append_byte_s;
    logic [31:0] byte_mask_s;
    logic [31:0] byte_word_s;

    assign byte_ready   = ((state_r == ST_DATA) || (state_r == ST_FF)) && (avail_r <= 6'd24);
    assign accept_s     = byte_valid && byte_ready;
    assign peek_bits    = buf_r[31:16];
    assign bits_avail   = avail_r;
    assign consume_err  = err_r;
    assign marker_valid = mv_r;
    assign marker_code  = mc_r;
    assign eoi_seen     = eoi_r;

    // Consume/append datapath and FSM next-state; the buffer keeps 1s below the valid bits.
    always_comb begin
        state_next_s  = state_r;
        mv_next_s     = mv_r;
        mc_next_s     = mc_r;
        eoi_next_s    = eoi_r;
        append_s      = 1'b0;
        append_byte_s = byte_in;

        cons_ok_s  = (state_r != ST_IDLE) && consume_valid && (consume_len != 5'd0)
                     && ({1'b0, consume_len} <= avail_r);
        cons_bad_s = (state_r != ST_IDLE) && consume_valid && ({1'b0, consume_len} > avail_r);
        err_next_s = cons_bad_s;

        if (cons_ok_s) begin
            shifted_s     = (buf_r << consume_len) | ~(32'hFFFF_FFFF << consume_len);
            avail_after_s = avail_r - {1'b0, consume_len};
        end else begin
            shifted_s     = buf_r;
            avail_after_s = avail_r;
        end

        case (state_r)
            ST_IDLE: begin
                state_next_s = ST_DATA;
            end
            ST_DATA: begin
                if (accept_s && (byte_in == 8'hFF)) begin
                    state_next_s = ST_FF;
                end else if (accept_s) begin
                    append_s = 1'b1;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_FF: begin
                if (accept_s && (byte_in == 8'h00)) begin
                    append_s      = 1'b1;
                    append_byte_s = 8'hFF;
                    state_next_s  = ST_DATA;
                end else if (accept_s && (byte_in != 8'hFF)) begin
                    mv_next_s    = 1'b1;
                    mc_next_s    = byte_in;
                    eoi_next_s   = eoi_r | (byte_in == 8'hD9);
                    state_next_s = ST_MARKER;
                end else begin
                    state_next_s = ST_FF;
                end
            end
            ST_MARKER: begin
                if (marker_ack) begin
                    mv_next_s    = 1'b0;
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_MARKER;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        byte_mask_s = 32'hFF00_0000 >> avail_after_s;
        byte_word_s = {append_byte_s, 24'h00_0000} >> avail_after_s;

        if ((state_r == ST_MARKER) && marker_ack) begin
            buf_next_s   = 32'hFFFF_FFFF;
            avail_next_s = 6'd0;
        end else if (append_s) begin
            buf_next_s   = (shifted_s & ~byte_mask_s) | byte_word_s;
            avail_next_s = avail_after_s + 6'd8;
        end else begin
            buf_next_s   = shifted_s;
            avail_next_s = avail_after_s;
        end
    end

    // State registers; start_scan low acts as the synchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            buf_r   <= 32'hFFFF_FFFF;
            avail_r <= 6'd0;
            err_r   <= 1'b0;
            mv_r    <= 1'b0;
            mc_r    <= 8'h00;
            eoi_r   <= 1'b0;
        end else if (!start_scan) begin
            state_r <= ST_IDLE;
            buf_r   <= 32'hFFFF_FFFF;
            avail_r <= 6'd0;
            err_r   <= 1'b0;
            mv_r    <= 1'b0;
            mc_r    <= 8'h00;
            eoi_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            buf_r   <= buf_next_s;
            avail_r <= avail_next_s;
            err_r   <= err_next_s;
            mv_r    <= mv_next_s;
            mc_r    <= mc_next_s;
            eoi_r   <= eoi_next_s;
        end
    end

endmodule
